addsub_sequencer: RTL and testbench

- Control stage directly upstream of the 4-bit combinational adder/subtractor.
- Collects operand A, operand B and the operation code over a valid/ready input handshake, then drives the adder's A, B and Select inputs from registers.
- Captures the adder's Out/Overflow one cycle later and presents the result on a valid/ready output handshake.
- Lets lab datapaths run add/subtract from a serial 4-bit source.

---
 rtl/addsub_sequencer.sv | 136 +++++++++++++
 tb/tb_addsub_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// addsub_sequencer
// Control stage in front of a WIDTH-bit combinational adder/subtractor.
// Collects operand A, then operand B plus the op code over a valid/ready
// handshake, drives the adder from registers for one EXEC cycle, captures
// the adder's result and flag, and offers them on a valid/ready output.
//
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   Start               begin an operation (IDLE, or DONE with Res_Ready)
//   Data_In, Op_In      operand word / op (1 = add, 0 = subtract), with B
//   Data_Valid/Ready    operand handshake
//   A_Out, B_Out,       registered adder inputs
//   Select_Out
//   Sum_In, Ovf_In      adder Out / Overflow
//   Result, Result_Ovf  captured adder output
//   Res_Valid/Ready     result handshake
//   Busy                high whenever not IDLE
//
// Optional build macro ADDSUB_SEQ_OVF_CNT_EN adds Ovf_Count[CNT_W-1:0], a
// saturating count of delivered results whose Result_Ovf was set.
module addsub_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Op_In,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  output logic [WIDTH-1:0] A_Out,
  output logic [WIDTH-1:0] B_Out,
  output logic             Select_Out,
  input  logic [WIDTH-1:0] Sum_In,
  input  logic             Ovf_In,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Ovf,
  output logic             Res_Valid,
  input  logic             Res_Ready,
  output logic             Busy
`ifdef ADDSUB_SEQ_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] Ovf_Count
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_DONE
  } state_t;

  state_t state;

  // Data_Ready, Res_Valid and Busy are registered: they are set on the
  // transition into the state that owns them, so they are glitch-free and
  // Data_Ready/Res_Valid can never overlap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      A_Out      <= '0;
      B_Out      <= '0;
      Select_Out <= 1'b0;
      Result     <= '0;
      Result_Ovf <= 1'b0;
      Res_Valid  <= 1'b0;
      Data_Ready <= 1'b0;
      Busy       <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_CNT_EN
      Ovf_Count  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state      <= S_LOAD_A;
            Data_Ready <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (Data_Valid && Data_Ready) begin
            A_Out <= Data_In;
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (Data_Valid && Data_Ready) begin
            B_Out      <= Data_In;
            Select_Out <= Op_In;
            Data_Ready <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          Result     <= Sum_In;
          Result_Ovf <= Ovf_In;
          Res_Valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_CNT_EN
            if (Result_Ovf && (Ovf_Count != '1)) begin
              Ovf_Count <= Ovf_Count + CNT_W'(1);
            end
`endif
            // Start together with the handshake skips IDLE entirely.
            if (Start) begin
              state      <= S_LOAD_A;
              Data_Ready <= 1'b1;
            end else begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          Data_Ready <= 1'b0;
          Res_Valid  <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer. The bench also plays the role of
// the downstream combinational adder/subtractor feeding Sum_In/Ovf_In.
module tb_addsub_sequencer;

  localparam int WIDTH = 4;
`ifdef ADDSUB_SEQ_OVF_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] Data_In = '0;
  logic             Op_In = 1'b0;
  logic             Data_Valid = 1'b0;
  logic             Data_Ready;
  logic [WIDTH-1:0] A_Out;
  logic [WIDTH-1:0] B_Out;
  logic             Select_Out;
  logic [WIDTH-1:0] Sum_In;
  logic             Ovf_In;
  logic [WIDTH-1:0] Result;
  logic             Result_Ovf;
  logic             Res_Valid;
  logic             Res_Ready = 1'b0;
  logic             Busy;
`ifdef ADDSUB_SEQ_OVF_CNT_EN
  logic [CNT_W-1:0] Ovf_Count;
`endif

  addsub_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Data_In    (Data_In),
    .Op_In      (Op_In),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
    .A_Out      (A_Out),
    .B_Out      (B_Out),
    .Select_Out (Select_Out),
    .Sum_In     (Sum_In),
    .Ovf_In     (Ovf_In),
    .Result     (Result),
    .Result_Ovf (Result_Ovf),
    .Res_Valid  (Res_Valid),
    .Res_Ready  (Res_Ready),
    .Busy       (Busy)
`ifdef ADDSUB_SEQ_OVF_CNT_EN
    ,
    .Ovf_Count  (Ovf_Count)
`endif
  );

  always #5 Clk = ~Clk;

  // Downstream adder/subtractor: bit 4 of the 5-bit difference is the borrow.
  logic [WIDTH:0] adder_full;
  always_comb begin
    adder_full = '0;
    if (Select_Out) adder_full = {1'b0, A_Out} + {1'b0, B_Out};
    else            adder_full = {1'b0, A_Out} - {1'b0, B_Out};
  end
  assign Sum_In = adder_full[WIDTH-1:0];
  assign Ovf_In = adder_full[WIDTH];

  int vectors = 0;
  int miscompares = 0;

  // Expected register contents of the sequencer, kept as plain integers.
  int exp_a = 0, exp_b = 0, exp_sel = 0, exp_r = 0, exp_f = 0, exp_cnt = 0;

  typedef struct {
    int a;
    int b;
    int op;
    int r;
    int f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ref_model(input int a, input int b, input int op);
    if (op != 0) begin
      exp_r = (a + b) % 16;
      exp_f = (a + b > 15) ? 1 : 0;
    end else begin
      exp_r = (a - b + 16) % 16;
      exp_f = (a < b) ? 1 : 0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Data_Valid = 1'b0; Res_Ready = 1'b0;
    tick();
    Reset = 1'b0;
    exp_a = 0; exp_b = 0; exp_sel = 0; exp_r = 0; exp_f = 0; exp_cnt = 0;
  endtask

  task automatic start_op();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_rdy", Data_Ready, 1);
    chk("start_busy", Busy, 1);
    chk("start_vld", Res_Valid, 0);
  endtask

  // Entered in LOAD_A; leaves the sequencer in DONE with the result checked.
  task automatic do_load(input int a, input int b, input int op,
                         input int gap_a, input int gap_b);
    Data_Valid = 1'b0;
    Data_In = 4'hF;
    repeat (gap_a) begin
      tick();
      chk("gap_a_rdy", Data_Ready, 1);
      chk("gap_a_hold", A_Out, exp_a);
    end
    Data_In = 4'(a); Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0; Data_In = 4'hF;
    exp_a = a;
    chk("load_a", A_Out, exp_a);
    chk("load_a_rdy", Data_Ready, 1);
    repeat (gap_b) begin
      tick();
      chk("gap_b_rdy", Data_Ready, 1);
      chk("gap_b_hold", B_Out, exp_b);
      chk("gap_b_a", A_Out, exp_a);
    end
    Data_In = 4'(b); Op_In = op[0]; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0; Op_In = ~Op_In;
    exp_b = b; exp_sel = op;
    chk("load_b", B_Out, exp_b);
    chk("load_sel", Select_Out, exp_sel);
    chk("exec_rdy", Data_Ready, 0);
    chk("exec_vld", Res_Valid, 0);
    chk("exec_busy", Busy, 1);
    ref_model(a, b, op);
    tick();
    chk("done_vld", Res_Valid, 1);
    chk("done_rdy", Data_Ready, 0);
    chk("result", Result, exp_r);
    chk("result_ovf", Result_Ovf, exp_f);
  endtask

  task automatic finish_op(input int with_start);
    Res_Ready = 1'b1; Start = with_start[0];
    tick();
    Res_Ready = 1'b0; Start = 1'b0;
    if (exp_f != 0 && exp_cnt < CNT_MAX) exp_cnt++;
    chk("hs_vld", Res_Valid, 0);
    chk("hs_busy", Busy, (with_start != 0) ? 1 : 0);
    chk("hs_rdy", Data_Ready, (with_start != 0) ? 1 : 0);
`ifdef ADDSUB_SEQ_OVF_CNT_EN
    chk("ovf_count", Ovf_Count, exp_cnt);
`endif
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{a: 7, b: 5, op: 1, r: 12, f: 0};
    tbl[1] = '{a: 9, b: 8, op: 1, r: 1,  f: 1};
    tbl[2] = '{a: 3, b: 5, op: 0, r: 14, f: 1};
    tbl[3] = '{a: 5, b: 3, op: 0, r: 2,  f: 0};

    Reset = 1'b1;
    tick();
    do_reset();
    chk("rst_busy", Busy, 0);
    chk("rst_rdy", Data_Ready, 0);
    chk("rst_vld", Res_Valid, 0);
    chk("rst_a", A_Out, 0);
    chk("rst_b", B_Out, 0);
    chk("rst_sel", Select_Out, 0);
    chk("rst_res", Result, 0);
    chk("rst_ovf", Result_Ovf, 0);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      start_op();
      do_load(tbl[i].a, tbl[i].b, tbl[i].op, 0, 0);
      chk("tbl_res", Result, tbl[i].r);
      chk("tbl_ovf", Result_Ovf, tbl[i].f);
      finish_op(0);
    end

    // IDLE ignores Data_Valid.
    Data_Valid = 1'b1; Data_In = 4'hA;
    repeat (2) begin
      tick();
      chk("idle_rdy", Data_Ready, 0);
      chk("idle_a", A_Out, exp_a);
      chk("idle_busy", Busy, 0);
    end
    Data_Valid = 1'b0;

    // Data_Valid gaps in both load states.
    start_op();
    do_load(11, 2, 0, 3, 3);
    finish_op(0);

    // Backpressure with a Start pulse that must be ignored.
    start_op();
    do_load(10, 9, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      Start = (i == 2) ? 1'b1 : 1'b0;
      tick();
      chk("bp_vld", Res_Valid, 1);
      chk("bp_res", Result, exp_r);
      chk("bp_ovf", Result_Ovf, exp_f);
      chk("bp_rdy", Data_Ready, 0);
    end
    Start = 1'b0;
    finish_op(0);
    tick();
    chk("bp_idle_busy", Busy, 0);
    chk("bp_idle_vld", Res_Valid, 0);

    // Reset in LOAD_B aborts the operation.
    start_op();
    Data_In = 4'd6; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    chk("pre_rst_a", A_Out, 6);
    do_reset();
    chk("abort_busy", Busy, 0);
    chk("abort_a", A_Out, 0);
    chk("abort_vld", Res_Valid, 0);
    chk("abort_rdy", Data_Ready, 0);
    tick();
    chk("abort_stay_idle", Busy, 0);
    start_op();
    do_load(4, 4, 1, 0, 0);
    finish_op(0);

    // Back-to-back: Start with Res_Ready goes straight to LOAD_A.
    start_op();
    do_load(1, 2, 0, 0, 0);
    finish_op(1);
    do_load(12, 3, 1, 0, 0);
    finish_op(0);

    // Randomized operations against the arithmetic reference.
    begin
      int chained = 0;
      for (int i = 0; i < 30; i++) begin
        int a, b, op, hold;
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(0, 15));
        op = int'($urandom_range(0, 1));
        if (chained == 0) start_op();
        do_load(a, b, op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        hold = int'($urandom_range(0, 2));
        repeat (hold) begin
          tick();
          chk("rnd_hold_vld", Res_Valid, 1);
          chk("rnd_hold_res", Result, exp_r);
        end
        chained = int'($urandom_range(0, 1));
        finish_op(chained);
      end
      if (chained != 0) begin
        do_load(0, 0, 1, 0, 0);
        finish_op(0);
      end
    end

`ifdef ADDSUB_SEQ_OVF_CNT_EN
    // Saturating overflow counter.
    do_reset();
    chk("cnt_rst", Ovf_Count, 0);
    for (int i = 0; i < 4; i++) begin
      start_op();
      do_load(15, 1, 1, 0, 0);
      finish_op(0);
      chk("cnt_sat_seq", Ovf_Count, (i < 3) ? i + 1 : 3);
    end
    start_op();
    do_load(1, 1, 1, 0, 0);
    finish_op(0);
    chk("cnt_no_ovf", Ovf_Count, 3);
    do_reset();
    chk("cnt_clear", Ovf_Count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
